picoregs_ctrl: RTL and testbench

- Access controller for the 32x32 dual-port block-RAM register file of the PicoRV32 core.
- Sits between the core's register read/write requests and the BRAM's A/B ports.
- Zeroes all registers after reset, hardwires x0, arbitrates write vs dual read onto two ports, and forwards same-cycle writes to reads.

---
 rtl/picoregs_pkg.sv | 15 +
 rtl/picoregs_if.sv | 32 +++
 rtl/picoregs_wbuf.sv | 46 ++++
 rtl/picoregs_ctrl.sv | 154 +++++++++++++++
 tb/tb_picoregs_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/picoregs_pkg.sv
// Shared definitions for the PicoRV32 block-RAM register file controller.
package picoregs_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;

    // Two registers are cleared per cycle (one per BRAM port), so 32 entries take 16 cycles.
    localparam int CLR_CYCLES = 16;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/picoregs_if.sv
// Core-side register read/write request bus of the register file controller.
interface picoregs_if
    import picoregs_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic              rdata_valid;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              init_done;

    modport master (
        output rd_valid, rs1, rs2, wr_valid, waddr, wdata,
        input  rd_ready, rdata_valid, rdata1, rdata2, wr_ready, init_done
    );

    modport slave (
        input  rd_valid, rs1, rs2, wr_valid, waddr, wdata,
        output rd_ready, rdata_valid, rdata1, rdata2, wr_ready, init_done
    );

endinterface

// File: rtl/picoregs_wbuf.sv
// One-entry buffer for a write that arrives together with a read. The read owns
// both BRAM ports that cycle, so the write is parked here and committed on the
// next cycle; meanwhile the held data is forwarded to the read that it overtook.
module picoregs_wbuf
    import picoregs_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture,
    input  logic              commit,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              fwd1,
    output logic              fwd2
);

    // Hold the parked write and remember which read operands it must override.
    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
            addr <= '0;
            data <= '0;
            fwd1 <= 1'b0;
            fwd2 <= 1'b0;
        end else begin
            fwd1 <= capture && (waddr == rs1);
            fwd2 <= capture && (waddr == rs2);
            if (capture) begin
                full <= 1'b1;
                addr <= waddr;
                data <= wdata;
            end else if (commit) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/picoregs_ctrl.sv
// Access controller between the PicoRV32 register requests and a 32x32
// dual-port BRAM: clears the RAM after reset, hardwires x0, serves two reads
// per cycle and forwards writes accepted in the same cycle as a read.
module picoregs_ctrl
    import picoregs_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    picoregs_if.slave         bus,
    output logic              ram_cea,
    output logic              ram_wrea,
    output logic [ADDR_W-1:0] ram_ada,
    output logic [DATA_W-1:0] ram_dina,
    input  logic [DATA_W-1:0] ram_douta,
    output logic              ram_ceb,
    output logic              ram_wreb,
    output logic [ADDR_W-1:0] ram_adb,
    output logic [DATA_W-1:0] ram_dinb,
    input  logic [DATA_W-1:0] ram_doutb,
    output logic              ram_oce,
    output logic              ram_reset
);

    localparam int                CNT_W    = ADDR_W - 1;
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYCLES - 1);

    state_t            state;
    logic [CNT_W-1:0]  clr_cnt;
    logic              ready_en;
    logic              init_done_q;
    logic              rdata_valid_q;
    logic [ADDR_W-1:0] rs1_q;
    logic [ADDR_W-1:0] rs2_q;

    logic              buf_full;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;
    logic              fwd1;
    logic              fwd2;

    logic              ready;
    logic              rd_fire;
    logic              wr_fire;
    logic              wr_live;

    assign ready   = ready_en & ~buf_full;
    assign rd_fire = bus.rd_valid & ready;
    assign wr_fire = bus.wr_valid & ready;
    assign wr_live = wr_fire & (bus.waddr != '0);

    picoregs_wbuf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wbuf (
        .clk     (clk),
        .reset   (reset),
        .capture (rd_fire & wr_live),
        .commit  (buf_full),
        .waddr   (bus.waddr),
        .wdata   (bus.wdata),
        .rs1     (bus.rs1),
        .rs2     (bus.rs2),
        .full    (buf_full),
        .addr    (buf_addr),
        .data    (buf_data),
        .fwd1    (fwd1),
        .fwd2    (fwd2)
    );

    // Sequence the clearing pass, then run; latch read operands for the output mux.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= CLEAR_ON_RESET ? INIT : RUN;
            clr_cnt       <= '0;
            init_done_q   <= !CLEAR_ON_RESET;
            ready_en      <= 1'b0;
            rdata_valid_q <= 1'b0;
            rs1_q         <= '0;
            rs2_q         <= '0;
        end else begin
            rdata_valid_q <= rd_fire;
            if (rd_fire) begin
                rs1_q <= bus.rs1;
                rs2_q <= bus.rs2;
            end
            case (state)
                INIT: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == CLR_LAST) begin
                        state       <= RUN;
                        init_done_q <= 1'b1;
                        ready_en    <= 1'b1;
                    end
                end
                RUN: begin
                    ready_en    <= 1'b1;
                    init_done_q <= 1'b1;
                end
                default: state <= INIT;
            endcase
        end
    end

    // Steer the BRAM ports: clearing pass, then buffered write, read pair, direct write.
    always_comb begin
        ram_cea  = 1'b0;
        ram_wrea = 1'b0;
        ram_ada  = '0;
        ram_dina = '0;
        ram_ceb  = 1'b0;
        ram_wreb = 1'b0;
        ram_adb  = '0;
        ram_dinb = '0;
        if (!reset) begin
            if (state == INIT) begin
                ram_cea  = 1'b1;
                ram_wrea = 1'b1;
                ram_ada  = {clr_cnt, 1'b0};
                ram_ceb  = 1'b1;
                ram_wreb = 1'b1;
                ram_adb  = {clr_cnt, 1'b1};
            end else if (buf_full) begin
                ram_cea  = 1'b1;
                ram_wrea = 1'b1;
                ram_ada  = buf_addr;
                ram_dina = buf_data;
            end else if (rd_fire) begin
                ram_cea = 1'b1;
                ram_ada = bus.rs1;
                ram_ceb = 1'b1;
                ram_adb = bus.rs2;
            end else if (wr_live) begin
                ram_cea  = 1'b1;
                ram_wrea = 1'b1;
                ram_ada  = bus.waddr;
                ram_dina = bus.wdata;
            end
        end
    end

    assign bus.rd_ready    = ready;
    assign bus.wr_ready    = ready;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.init_done   = init_done_q;
    assign bus.rdata1      = (rs1_q == '0) ? '0 : (fwd1 ? buf_data : ram_douta);
    assign bus.rdata2      = (rs2_q == '0) ? '0 : (fwd2 ? buf_data : ram_doutb);
    assign ram_oce         = 1'b1;
    assign ram_reset       = reset;

endmodule

// File: tb/tb_picoregs_ctrl.sv
// Randomised self-checking bench for picoregs_ctrl with a behavioural BRAM and
// an architectural register-file reference model.
module tb_picoregs_ctrl;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          ram_cea, ram_wrea, ram_ceb, ram_wreb, ram_oce, ram_reset;
    logic [AW-1:0] ram_ada, ram_adb;
    logic [DW-1:0] ram_dina, ram_dinb, ram_douta, ram_doutb;

    logic [DW-1:0] bram [32];
    logic [DW-1:0] regs [32];

    int      n_checks;
    int      n_pass;
    int      init_idx;
    int      rv_pulses;
    bit      m_run;
    bit      m_bubble;
    bit      m_pend;
    bit      prev_rst;
    logic [DW-1:0] m_exp1;
    logic [DW-1:0] m_exp2;

    picoregs_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    picoregs_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .ram_cea   (ram_cea),
        .ram_wrea  (ram_wrea),
        .ram_ada   (ram_ada),
        .ram_dina  (ram_dina),
        .ram_douta (ram_douta),
        .ram_ceb   (ram_ceb),
        .ram_wreb  (ram_wreb),
        .ram_adb   (ram_adb),
        .ram_dinb  (ram_dinb),
        .ram_doutb (ram_doutb),
        .ram_oce   (ram_oce),
        .ram_reset (ram_reset)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Dual-port BRAM with one-cycle read latency.
    always @(posedge clk) begin
        if (ram_cea) begin
            if (ram_wrea) bram[ram_ada] <= ram_dina;
            else          ram_douta     <= bram[ram_ada];
        end
        if (ram_ceb) begin
            if (ram_wreb) bram[ram_adb] <= ram_dinb;
            else          ram_doutb     <= bram[ram_adb];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Reference model: architectural registers, bubble after a coincident write,
    // read results due one cycle after acceptance.
    task automatic modelStep();
        bit rf;
        bit wf;
        if (reset) begin
            checkOutput("reset_ram_quiet", 64'({ram_cea, ram_ceb, ram_wrea, ram_wreb}), 64'(0));
            checkOutput("oce_reset", 64'({ram_oce, ram_reset}), 64'(2'b11));
            if (prev_rst)
                checkOutput("reset_flops", 64'({bus.rd_ready, bus.wr_ready, bus.init_done, bus.rdata_valid}), 64'(0));
            m_run    = 1'b0;
            init_idx = 0;
            m_pend   = 1'b0;
            m_bubble = 1'b0;
            for (int i = 0; i < 32; i++) regs[i] = '0;
        end else if (!m_run) begin
            checkOutput("init_ports",
                64'({ram_cea, ram_ceb, ram_wrea, ram_wreb, ram_ada, ram_adb,
                     bus.rd_ready, bus.wr_ready, bus.init_done, bus.rdata_valid}),
                64'({4'b1111, 5'(2 * init_idx), 5'(2 * init_idx + 1), 4'b0000}));
            checkOutput("init_data", 64'({ram_dina, ram_dinb}), 64'(0));
            init_idx++;
            if (init_idx == 16) m_run = 1'b1;
        end else begin
            checkOutput("ready", 64'({bus.rd_ready, bus.wr_ready, bus.init_done}),
                        64'({!m_bubble, !m_bubble, 1'b1}));
            checkOutput("rdata_valid", 64'(bus.rdata_valid), 64'(m_pend));
            if (m_pend && bus.rdata_valid)
                checkOutput("rdata", {bus.rdata1, bus.rdata2}, {m_exp1, m_exp2});
            checkOutput("bad_write", 64'((ram_wrea && ram_ada == '0) || ram_wreb), 64'(0));
            rf = bus.rd_valid && !m_bubble;
            wf = bus.wr_valid && !m_bubble;
            if (wf && bus.waddr != '0) regs[bus.waddr] = bus.wdata;
            if (rf) begin
                m_exp1 = regs[bus.rs1];
                m_exp2 = regs[bus.rs2];
            end
            m_pend   = rf;
            m_bubble = rf && wf && (bus.waddr != '0);
        end
        if (bus.rdata_valid === 1'b1) rv_pulses++;
        prev_rst = reset;
    endtask

    // Drive one cycle of inputs just after the edge, then check at the falling edge.
    task automatic applyStimulus(input logic rst, input logic rv, input logic [AW-1:0] a1,
                                 input logic [AW-1:0] a2, input logic wv,
                                 input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        @(posedge clk);
        #1;
        reset        = rst;
        bus.rd_valid = rv;
        bus.rs1      = a1;
        bus.rs2      = a2;
        bus.wr_valid = wv;
        bus.waddr    = wa;
        bus.wdata    = wd;
        @(negedge clk);
        modelStep();
    endtask

    task automatic randomCycle(input int rd_pct, input int wr_pct);
        applyStimulus(1'b0, 1'($urandom_range(99) < rd_pct), AW'($urandom), AW'($urandom),
                      1'($urandom_range(99) < wr_pct), AW'($urandom), $urandom);
    endtask

    // Directed scenarios followed by randomised traffic and a final RAM image compare.
    initial begin
        n_checks = 0;
        n_pass   = 0;
        prev_rst = 1'b0;
        m_run    = 1'b0;
        init_idx = 0;
        for (int i = 0; i < 32; i++) bram[i] = $urandom;
        reset = 1'b1;
        bus.rd_valid = 1'b0; bus.rs1 = '0; bus.rs2 = '0;
        bus.wr_valid = 1'b0; bus.waddr = '0; bus.wdata = '0;

        repeat (3) applyStimulus(1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 32'h1);
        repeat (16) randomCycle(50, 50);

        applyStimulus(1'b0, 1'b1, 5'd5, 5'd31, 1'b0, 5'd0, 32'h0);
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'hDEADBEEF);
        checkOutput("x5_x31_zero", {bus.rdata1, bus.rdata2}, 64'h0);
        applyStimulus(1'b0, 1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 32'h0);
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
        checkOutput("x3_read", {bus.rdata1, bus.rdata2}, {32'hDEADBEEF, 32'h0});

        applyStimulus(1'b0, 1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 32'h12345678);
        applyStimulus(1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 5'd4, 32'hCAFEF00D);
        checkOutput("x7_forward", {bus.rdata1, bus.rdata2}, {32'h12345678, 32'h12345678});
        checkOutput("buffer_commit",
                    64'({bus.rd_ready, bus.wr_ready, ram_cea, ram_wrea, ram_ada, ram_dina}),
                    64'({4'b0011, 5'd7, 32'h12345678}));
        applyStimulus(1'b0, 1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 32'h0);
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
        checkOutput("x7_after_commit", 64'(bus.rdata1), 64'(32'h12345678));

        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
        checkOutput("x0_no_write", 64'({ram_cea, ram_wrea}), 64'(0));
        applyStimulus(1'b0, 1'b1, 5'd0, 5'd3, 1'b0, 5'd0, 32'h0);
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
        checkOutput("x0_read", 64'(bus.rdata1), 64'(0));

        rv_pulses = 0;
        for (int i = 0; i < 20; i++)
            applyStimulus(1'b0, 1'b1, AW'($urandom), AW'($urandom), 1'b0, 5'd0, 32'h0);
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
        checkOutput("back_to_back", 64'(rv_pulses), 64'(20));

        rv_pulses = 0;
        for (int i = 0; i < 20; i++)
            applyStimulus(1'b0, 1'b1, AW'($urandom), AW'($urandom), 1'(i == 5),
                          AW'($urandom_range(31, 1)), $urandom);
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
        checkOutput("one_bubble", 64'(rv_pulses), 64'(19));

        repeat (300) randomCycle(70, 40);

        applyStimulus(1'b0, 1'b1, 5'd9, 5'd9, 1'b1, 5'd9, 32'hA5A5A5A5);
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
        checkOutput("buffer_dropped", 64'({ram_cea, ram_wrea}), 64'(0));
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
        repeat (9) randomCycle(50, 50);
        applyStimulus(1'b1, 1'b1, 5'd2, 5'd3, 1'b1, 5'd4, 32'h5);
        checkOutput("reset_mid_init", 64'(init_idx), 64'(0));
        repeat (16) randomCycle(50, 50);
        applyStimulus(1'b0, 1'b1, 5'd9, 5'd4, 1'b0, 5'd0, 32'h0);

        repeat (200) randomCycle(60, 50);
        repeat (3) applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 32; i++)
            checkOutput($sformatf("ram_image_%0d", i), 64'(bram[i]), 64'(regs[i]));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
